// File: rtl/rotary_pkg.sv
// rtl/rotary_pkg.sv - shared FSM state encoding and quadrature codes for the rotary controller
package rotary_pkg;

  // Per-channel quadrature decoder states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CW1    = 3'd1,
    ST_CW2    = 3'd2,
    ST_CW3    = 3'd3,
    ST_CCW1   = 3'd4,
    ST_CCW2   = 3'd5,
    ST_CCW3   = 3'd6,
    ST_RESYNC = 3'd7
  } rot_state_e;

  // Pin-pair codes, ordered {B, A}
  localparam logic [1:0] CODE_00 = 2'b00;
  localparam logic [1:0] CODE_01 = 2'b01;
  localparam logic [1:0] CODE_11 = 2'b11;
  localparam logic [1:0] CODE_10 = 2'b10;

endpackage

// File: rtl/rotary_chan.sv
// rtl/rotary_chan.sv - one encoder channel: synchroniser, debouncer, decoder FSM, position counter
module rotary_chan
  import rotary_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int DEBOUNCE = 4,
  parameter int WRAP     = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       pins_i,
  input  logic             clr_i,
  output logic             cw_o,
  output logic             ccw_o,
  output logic             err_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [7:0]       DB_LIM  = 8'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       cand_q, cand_d;
  logic [7:0]       stab_q, stab_d;
  logic [1:0]       deb_q, deb_d, deb_prev_q;
  rot_state_e       state_q, state_d;
  logic             cw_q, cw_d, ccw_q, ccw_d, err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       chg;

  // Debounce: accept the synchronised pair once it has held one new value long enough
  always_comb begin
    cand_d = sync2_q;
    stab_d = 8'd0;
    deb_d  = deb_q;
    if (sync2_q != deb_q) begin
      stab_d = (sync2_q == cand_q) ? stab_q + 8'd1 : 8'd1;
      if (stab_d >= DB_LIM) begin
        deb_d  = sync2_q;
        stab_d = 8'd0;
      end
    end
  end

  assign chg = deb_q ^ deb_prev_q;

  // Decoder FSM: steps only when the debounced pair has just changed
  always_comb begin
    state_d = state_q;
    cw_d    = 1'b0;
    ccw_d   = 1'b0;
    err_d   = 1'b0;
    if (chg == 2'b11) begin
      err_d   = 1'b1;
      state_d = ST_RESYNC;
    end else if (chg != 2'b00) begin
      case (state_q)
        ST_IDLE:   if (deb_q == CODE_01) state_d = ST_CW1;
                   else if (deb_q == CODE_10) state_d = ST_CCW1;
        ST_CW1:    if (deb_q == CODE_11) state_d = ST_CW2;
                   else if (deb_q == CODE_00) state_d = ST_IDLE;
        ST_CW2:    if (deb_q == CODE_10) state_d = ST_CW3;
                   else if (deb_q == CODE_01) state_d = ST_CW1;
        ST_CW3:    if (deb_q == CODE_00) begin state_d = ST_IDLE; cw_d = 1'b1; end
                   else if (deb_q == CODE_11) state_d = ST_CW2;
        ST_CCW1:   if (deb_q == CODE_11) state_d = ST_CCW2;
                   else if (deb_q == CODE_00) state_d = ST_IDLE;
        ST_CCW2:   if (deb_q == CODE_01) state_d = ST_CCW3;
                   else if (deb_q == CODE_10) state_d = ST_CCW1;
        ST_CCW3:   if (deb_q == CODE_00) begin state_d = ST_IDLE; ccw_d = 1'b1; end
                   else if (deb_q == CODE_11) state_d = ST_CCW2;
        ST_RESYNC: if (deb_q == CODE_00) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Position counter: clear wins over a detent; WRAP selects modulo or saturating limits
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (cw_d) begin
      if (count_q != CNT_MAX)  count_d = count_q + 1'b1;
      else if (WRAP != 0)      count_d = '0;
    end else if (ccw_d) begin
      if (count_q != '0)       count_d = count_q - 1'b1;
      else if (WRAP != 0)      count_d = CNT_MAX;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q    <= 2'b00;
      sync2_q    <= 2'b00;
      cand_q     <= 2'b00;
      stab_q     <= 8'd0;
      deb_q      <= 2'b00;
      deb_prev_q <= 2'b00;
      state_q    <= ST_IDLE;
      cw_q       <= 1'b0;
      ccw_q      <= 1'b0;
      err_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      sync1_q    <= pins_i;
      sync2_q    <= sync1_q;
      cand_q     <= cand_d;
      stab_q     <= stab_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      state_q    <= state_d;
      cw_q       <= cw_d;
      ccw_q      <= ccw_d;
      err_q      <= err_d;
      count_q    <= count_d;
    end
  end

  assign cw_o    = cw_q;
  assign ccw_o   = ccw_q;
  assign err_o   = err_q;
  assign count_o = count_q;

endmodule

// File: rtl/rotary_multi_ctl.sv
// rtl/rotary_multi_ctl.sv - multi-channel quadrature rotary encoder controller
module rotary_multi_ctl
  import rotary_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 8,
  parameter int DEBOUNCE = 4,
  parameter int WRAP     = 1
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset_n,
  input  logic [2*CHANNELS-1:0]     rotary_in,
  input  logic [CHANNELS-1:0]       clr,
  output logic [CHANNELS-1:0]       rotary_cw,
  output logic [CHANNELS-1:0]       rotary_ccw,
  output logic [CHANNELS*CNT_W-1:0] count,
  output logic [CHANNELS-1:0]       err
);

  // One independent decoder per encoder
  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    rotary_chan #(
      .CNT_W    (CNT_W),
      .DEBOUNCE (DEBOUNCE),
      .WRAP     (WRAP)
    ) u_chan (
      .clk_i   (clk_clk),
      .rst_ni  (reset_reset_n),
      .pins_i  (rotary_in[2*g +: 2]),
      .clr_i   (clr[g]),
      .cw_o    (rotary_cw[g]),
      .ccw_o   (rotary_ccw[g]),
      .err_o   (err[g]),
      .count_o (count[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_rotary_multi_ctl.sv
// tb/tb_rotary_multi_ctl.sv - directed self-checking bench for rotary_multi_ctl
module tb_rotary_multi_ctl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  rotary_in;
  logic [1:0]  clr;
  logic [1:0]  cw_a, ccw_a, err_a, cw_b, ccw_b, err_b;
  logic [15:0] count_a, count_b;

  int checks = 0;
  int errors = 0;

  int cw_n[2], ccw_n[2], err_n[2], cw_at[2];
  int cw_b_n, ccw_b_n;
  logic [7:0] cnt0_at_cw;

  always #5 clk = ~clk;

  rotary_multi_ctl #(.CHANNELS(2), .CNT_W(8), .DEBOUNCE(4), .WRAP(1)) dut_wrap (
    .clk_clk(clk), .reset_reset_n(rstn), .rotary_in(rotary_in), .clr(clr),
    .rotary_cw(cw_a), .rotary_ccw(ccw_a), .count(count_a), .err(err_a)
  );

  rotary_multi_ctl #(.CHANNELS(2), .CNT_W(8), .DEBOUNCE(4), .WRAP(0)) dut_sat (
    .clk_clk(clk), .reset_reset_n(rstn), .rotary_in(rotary_in), .clr(clr),
    .rotary_cw(cw_b), .rotary_ccw(ccw_b), .count(count_b), .err(err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    for (int c = 0; c < 2; c++) begin
      cw_n[c] = 0; ccw_n[c] = 0; err_n[c] = 0; cw_at[c] = 0;
    end
    cw_b_n = 0; ccw_b_n = 0; cnt0_at_cw = 8'hxx;
  endtask

  // Hold pins for n cycles, sampling on falling edges; clr[0] raised on cycle clr_at (0 = never)
  task automatic drive(input logic [3:0] pins, input int n, input int clr_at);
    rotary_in = pins;
    for (int i = 1; i <= n; i++) begin
      clr = (i == clr_at) ? 2'b01 : 2'b00;
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if (cw_a[c])  begin cw_n[c]++; cw_at[c] = i; end
        if (ccw_a[c]) ccw_n[c]++;
        if (err_a[c]) err_n[c]++;
      end
      if (cw_a[0]) cnt0_at_cw = count_a[7:0];
      if (cw_b[0]) cw_b_n++;
      if (ccw_b[0]) ccw_b_n++;
    end
    clr = 2'b00;
  endtask

  task automatic cw0_detent(input int clr_at);
    drive(4'b0001, 10, 0);
    drive(4'b0011, 10, 0);
    drive(4'b0010, 10, 0);
    drive(4'b0000, 10, clr_at);
  endtask

  initial begin
    rstn = 1'b0; rotary_in = 4'b0000; clr = 2'b00;
    clear_stats();

    // Reset held for 3 cycles
    repeat (3) @(negedge clk);
    check("rst_count_wrap", count_a, 16'h0000);
    check("rst_count_sat", count_b, 16'h0000);
    check("rst_pulses", {cw_a, ccw_a, err_a}, 6'b0);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_count", count_a, 16'h0000);
    check("post_rst_pulses", {cw_a, ccw_a, err_a, cw_b, ccw_b, err_b}, 12'b0);

    // One clockwise detent on ch0
    clear_stats();
    cw0_detent(0);
    check("cw_pulses", cw_n[0], 1);
    check("cw_latency", cw_at[0], 7);
    check("cw_count0", count_a[7:0], 8'd1);
    check("cw_count1", count_a[15:8], 8'd0);
    check("cw_no_ccw_err", ccw_n[0] + err_n[0] + cw_n[1], 0);
    check("cw_count0_sat", count_b[7:0], 8'd1);

    // Clear, then ccw detent underflow
    drive(4'b0000, 1, 1);
    check("clr_count0", count_a[7:0], 8'd0);
    check("clr_count0_sat", count_b[7:0], 8'd0);
    clear_stats();
    drive(4'b0010, 10, 0);
    drive(4'b0011, 10, 0);
    drive(4'b0001, 10, 0);
    drive(4'b0000, 10, 0);
    check("ccw_pulses", ccw_n[0], 1);
    check("ccw_wrap_count", count_a[7:0], 8'd255);
    check("ccw_sat_count", count_b[7:0], 8'd0);
    check("ccw_sat_pulse", ccw_b_n, 1);

    // cw at 255 wraps to 0; saturating copy goes 0 -> 1
    clear_stats();
    cw0_detent(0);
    check("wrap_up_count", count_a[7:0], 8'd0);
    check("sat_up_count", count_b[7:0], 8'd1);
    check("wrap_up_pulse", cw_n[0], 1);

    // Ch1 glitch shorter than debounce, then partial sequence
    clear_stats();
    drive(4'b0100, 2, 0);
    drive(4'b0000, 10, 0);
    drive(4'b0100, 10, 0);
    drive(4'b0000, 10, 0);
    check("glitch_pulses", cw_n[1] + ccw_n[1] + err_n[1], 0);
    check("glitch_count1", count_a[15:8], 8'd0);
    drive(4'b0100, 10, 0);
    drive(4'b1100, 10, 0);
    drive(4'b1000, 10, 0);
    drive(4'b0000, 10, 0);
    check("ch1_cw_pulse", cw_n[1], 1);
    check("ch1_count", count_a[15:8], 8'd1);
    check("ch1_ch0_untouched", count_a[7:0], 8'd0);

    // Illegal jump on ch0, recovery through 00
    clear_stats();
    drive(4'b0011, 10, 0);
    check("jump_err", err_n[0], 1);
    check("jump_count", count_a[7:0], 8'd0);
    drive(4'b0010, 10, 0);
    drive(4'b0000, 10, 0);
    check("resync_no_pulse", cw_n[0] + ccw_n[0] + err_n[0], 1);
    cw0_detent(0);
    check("resync_cw_count", count_a[7:0], 8'd1);
    check("resync_cw_count_sat", count_b[7:0], 8'd2);

    // Clear on the pulse cycle wins over the increment
    clear_stats();
    cw0_detent(7);
    check("clr_pulse_seen", cw_n[0], 1);
    check("clr_pulse_count", cnt0_at_cw, 8'd0);
    check("clr_after_count", count_a[7:0], 8'd0);
    check("clr_sat_count", count_b[7:0], 8'd0);

    // Simultaneous cw on both channels
    clear_stats();
    drive(4'b0101, 10, 0);
    drive(4'b1111, 10, 0);
    drive(4'b1010, 10, 0);
    drive(4'b0000, 10, 0);
    check("simul_at0", cw_at[0], 7);
    check("simul_at1", cw_at[1], 7);
    check("simul_counts", count_a, 16'h0201);
    check("simul_counts_sat", count_b, 16'h0201);

    // Reset mid-sequence discards progress
    clear_stats();
    drive(4'b0001, 10, 0);
    drive(4'b0011, 10, 0);
    rstn = 1'b0;
    drive(4'b0011, 3, 0);
    rstn = 1'b1;
    check("midrst_count", count_a, 16'h0000);
    clear_stats();
    drive(4'b0011, 10, 0);
    drive(4'b0010, 10, 0);
    drive(4'b0000, 10, 0);
    check("midrst_err", err_n[0], 1);
    check("midrst_no_cw", cw_n[0], 0);
    cw0_detent(0);
    check("midrst_cw", cw_n[0], 1);
    check("midrst_count_after", count_a[7:0], 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rotary_multi_ctl.md
ROTARY_MULTI_CTL -- requirements
Module: rotary_multi_ctl

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent quadrature encoders.
REQ-002 SHALL have parameter CNT_W, default 8: width of each position counter.
REQ-003 SHALL have parameter DEBOUNCE, default 4: cycles the synchronised input pair must be stable before acceptance, range 1..255.
REQ-004 SHALL have parameter WRAP, default 1: 1 = counter wraps modulo 2^CNT_W, 0 = counter saturates at 0 and 2^CNT_W-1.
REQ-005 SHALL have port clk_clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_reset_n, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port rotary_in, input, 2*CHANNELS: raw encoder pins; channel c uses bits [2c+1:2c], bit 2c = A, bit 2c+1 = B.
REQ-008 SHALL have port clr, input, CHANNELS: per-channel synchronous counter clear.
REQ-009 SHALL have port rotary_cw, output, CHANNELS: one-cycle pulse per completed clockwise detent.
REQ-010 SHALL have port rotary_ccw, output, CHANNELS: one-cycle pulse per completed counter-clockwise detent.
REQ-011 SHALL have port count, output, CHANNELS*CNT_W: unsigned positions; channel c in [c*CNT_W +: CNT_W].
REQ-012 SHALL have port err, output, CHANNELS: one-cycle pulse on an illegal two-bit jump.

Function
REQ-013 Each channel SHALL pass its pin pair through a 2-flop synchroniser.
REQ-014 The debounced pair SHALL update only after the synchronised pair differs from it and holds the same new value for DEBOUNCE consecutive cycles; any change restarts the stability count.
REQ-015 Per-channel FSM states SHALL be IDLE, CW1, CW2, CW3, CCW1, CCW2, CCW3, RESYNC, evaluated only on cycles where the debounced pair changes.
REQ-016 Clockwise sequence SHALL be BA = 00->01->11->10->00 (IDLE->CW1->CW2->CW3->IDLE); counter-clockwise SHALL be 00->10->11->01->00 (IDLE->CCW1->CCW2->CCW3->IDLE).
REQ-017 A single-bit change that reverses along the sequence SHALL move the FSM back one state, and a return to 00 without completing the sequence SHALL go to IDLE with no pulse.
REQ-018 CW3->IDLE SHALL assert rotary_cw, and CCW3->IDLE SHALL assert rotary_ccw, for exactly one cycle, registered on the edge following the debounced change.
REQ-019 A debounced change of both bits at once SHALL pulse err for one cycle, produce no cw/ccw, and enter RESYNC; RESYNC SHALL go to IDLE only when the debounced pair equals 00.
REQ-020 Count SHALL update on the same edge that registers the cw/ccw pulse: +1 on cw, -1 on ccw, so the new value is visible in the pulse cycle.
REQ-021 In WRAP=1 mode, 2^CNT_W-1 +1 SHALL give 0 and 0 -1 SHALL give 2^CNT_W-1; in WRAP=0 mode both SHALL hold their value, while the pulse still asserts.
REQ-022 clr[c] SHALL force count c to 0 on the next edge, with priority over a simultaneous cw/ccw event; the pulse itself still asserts.
REQ-023 Channels SHALL be fully independent; simultaneous events on different channels SHALL all be honoured in the same cycle.
REQ-024 Pin-to-pulse latency SHALL be 2 (sync) + DEBOUNCE + 1 cycles after the final transition.

Reset
REQ-025 While reset_reset_n=0 at an edge: all counts 0, rotary_cw/rotary_ccw/err 0, FSMs IDLE, debounced pairs and synchronisers 00, stability counters 0.
REQ-026 Reset mid-sequence SHALL discard partial progress; after release the first detent SHALL be counted only if it starts from 00.

Structure
REQ-027 A package rotary_pkg SHALL hold the FSM state enum and the sequence-code constants (00, 01, 11, 10).
REQ-028 A sub-module rotary_chan (synchroniser, debouncer, FSM, counter for one channel) SHALL be instantiated CHANNELS times by a generate loop.

Verification (CHANNELS=2, CNT_W=8, DEBOUNCE=4)
REQ-029 Reset held for 3 cycles, then released -> count=0x0000, all pulses 0.
REQ-030 Ch0 driven 00,01,11,10,00, each held 10 cycles -> exactly one rotary_cw[0] pulse, 7 cycles after the final edge; count[7:0]=1; ch1 unchanged.
REQ-031 From count 0, one ccw detent -> WRAP=1: count=255; WRAP=0: count=0 with rotary_ccw pulse.
REQ-032 Ch1 at 00, glitch to 01 for 2 cycles then 00 -> no state change, no pulse; partial sequence 00->01->00 -> no pulse, count unchanged.
REQ-033 Ch0 jump 00->11 -> err[0] single pulse, no count change; then 11->10->00 -> no pulse; the next full cw detent -> count +1.
REQ-034 clr[0] asserted on the cycle a cw pulse is registered -> count[7:0]=0 next cycle, rotary_cw[0] pulse still seen.
